// File: rtl/datapath_arbiter.sv
// datapath_arbiter: round-robin burst arbiter sharing one datapath
// between requesters through a single registered valid/ready stage.
module datapath_arbiter #(
  parameter int WIDTH          = 8,
  parameter int NOF_REQUESTERS = 4,
  parameter int MAX_BURST      = 4,
  parameter int ID_WIDTH       = $clog2(NOF_REQUESTERS)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NOF_REQUESTERS-1:0]       req_valid_i,
  input  logic [NOF_REQUESTERS*WIDTH-1:0] req_data_i,
  input  logic [NOF_REQUESTERS-1:0]       req_last_i,
  output logic [NOF_REQUESTERS-1:0]       req_ready_o,
  output logic [NOF_REQUESTERS-1:0]       grant_o,
  output logic                            dp_valid_o,
  output logic [WIDTH-1:0]                dp_data_o,
  output logic [ID_WIDTH-1:0]             dp_id_o,
  output logic                            dp_last_o,
  input  logic                            dp_ready_i
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CntLast = CW'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] IdMax = ID_WIDTH'(NOF_REQUESTERS - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                    state_q;
  logic [NOF_REQUESTERS-1:0] grant_q;
  logic [NOF_REQUESTERS-1:0] grant_d;
  logic [ID_WIDTH-1:0]       gid_q;
  logic [ID_WIDTH-1:0]       ptr_q;
  logic [ID_WIDTH-1:0]       ptr_d;
  logic [CW-1:0]             cnt_q;
  logic                      dp_valid_q;
  logic                      dp_last_q;
  logic [WIDTH-1:0]          dp_data_q;
  logic [ID_WIDTH-1:0]       dp_id_q;

  logic                      sel_valid;
  logic                      sel_last;
  logic [WIDTH-1:0]          sel_data;
  logic                      stage_free;
  logic                      accept;
  logic                      beat_last;

  logic                      hi_found;
  logic                      lo_found;
  logic [ID_WIDTH-1:0]       hi_idx;
  logic [ID_WIDTH-1:0]       lo_idx;
  logic                      pick_valid;
  logic [ID_WIDTH-1:0]       pick_idx;

  // Lane of the currently granted requester
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NOF_REQUESTERS; i++) begin
      if (grant_q[i]) begin
        sel_valid = req_valid_i[i];
        sel_last  = req_last_i[i];
        sel_data  = req_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign stage_free  = ~dp_valid_q | dp_ready_i;
  assign req_ready_o = grant_q & {NOF_REQUESTERS{stage_free}};
  assign accept      = sel_valid & stage_free;
  assign beat_last   = sel_last | (cnt_q == CntLast);

  // Round-robin: lowest requester at or above the pointer, else lowest below
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NOF_REQUESTERS - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        if (ID_WIDTH'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = ID_WIDTH'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = ID_WIDTH'(i);
        end
      end
    end
  end

  assign pick_valid = hi_found | lo_found;
  assign pick_idx   = hi_found ? hi_idx : lo_idx;

  always_comb begin
    grant_d           = '0;
    grant_d[pick_idx] = 1'b1;
  end

  assign ptr_d = (gid_q == IdMax) ? '0 : gid_q + ID_WIDTH'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gid_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_data_q  <= '0;
      dp_id_q    <= '0;
      dp_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        dp_valid_q <= 1'b1;
        dp_data_q  <= sel_data;
        dp_id_q    <= gid_q;
        dp_last_q  <= beat_last;
      end else if (dp_ready_i) begin
        dp_valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= grant_d;
            gid_q   <= pick_idx;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            cnt_q <= cnt_q + CW'(1);
            if (beat_last) begin
              grant_q <= '0;
              ptr_q   <= ptr_d;
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign dp_valid_o = dp_valid_q;
  assign dp_data_o  = dp_data_q;
  assign dp_id_o    = dp_id_q;
  assign dp_last_o  = dp_last_q;

endmodule

// File: tb/tb_datapath_arbiter.sv
// tb_datapath_arbiter: directed scenarios plus random traffic checked
// cycle by cycle against a transaction-level arbiter model.
module tb_datapath_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           dp_valid;
  logic [W-1:0]   dp_data;
  logic [1:0]     dp_id;
  logic           dp_last;
  logic           dp_ready = 1'b0;

  datapath_arbiter #(
    .WIDTH(W), .NOF_REQUESTERS(N), .MAX_BURST(MB)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(req_ready),
    .grant_o(grant), .dp_valid_o(dp_valid),
    .dp_data_o(dp_data), .dp_id_o(dp_id),
    .dp_last_o(dp_last), .dp_ready_i(dp_ready)
  );

  int checks = 0;
  int errors = 0;

  // per-requester beat stores: {last, data}
  logic [W:0] mem [N][256];
  int head [N];
  int tail [N];

  logic [N-1:0] en = '1;
  bit  rand_en = 1'b0;
  int  rdy_mode = 1;
  bit  rst_req = 1'b1;

  // reference model
  logic [N-1:0] grant_m;
  int           ptr_m;
  int           bcnt;
  logic         mv;
  logic [1:0]   mid;
  logic [W-1:0] md;
  logic         ml;

  int seen_id[$];
  int seen_d[$];
  int seen_l[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(int n, logic [W-1:0] d, bit l);
    mem[n][tail[n]] = {l, d};
    tail[n]++;
  endtask

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    grant_m = '0;
    ptr_m   = 0;
    bcnt    = 0;
    mv      = 1'b0;
    mid     = '0;
    md      = '0;
    ml      = 1'b0;
    for (int n = 0; n < N; n++) head[n] = tail[n];
  endtask

  task automatic tick();
    logic [N-1:0] exp_rdy;
    int g;
    int p;
    bit lst;
    @(negedge clk);
    rst = rst_req;
    if (rand_en) en = N'($urandom);
    for (int n = 0; n < N; n++) begin
      if (head[n] != tail[n] && en[n]) begin
        req_valid[n]         = 1'b1;
        req_data[n*W +: W]   = mem[n][head[n]][W-1:0];
        req_last[n]          = mem[n][head[n]][W];
      end else begin
        req_valid[n]         = 1'b0;
        req_data[n*W +: W]   = W'($urandom);
        req_last[n]          = 1'($urandom);
      end
    end
    if (rdy_mode == 2) dp_ready = ($urandom_range(0, 3) != 0);
    else dp_ready = (rdy_mode == 1);
    #1;
    exp_rdy = (mv && !dp_ready) ? '0 : grant_m;
    chk("grant", grant, grant_m);
    chk("req_ready", req_ready, exp_rdy);
    chk("dp_valid", dp_valid, mv);
    if (mv) begin
      chk("dp_data", dp_data, md);
      chk("dp_id", dp_id, mid);
      chk("dp_last", dp_last, ml);
    end
    if (dp_valid && dp_ready) begin
      seen_id.push_back(int'(dp_id));
      seen_d.push_back(int'(dp_data));
      seen_l.push_back(int'(dp_last));
    end
    if (rst) begin
      model_reset();
    end else begin
      g = -1;
      for (int n = 0; n < N; n++) if (grant_m[n]) g = n;
      if (g >= 0 && req_valid[g] && exp_rdy[g]) begin
        bcnt++;
        lst = req_last[g] || (bcnt == MB);
        mid = 2'(g);
        md  = req_data[g*W +: W];
        ml  = lst;
        mv  = 1'b1;
        head[g]++;
        if (lst) begin
          grant_m = '0;
          ptr_m   = (g + 1) % N;
        end
      end else if (dp_ready) begin
        mv = 1'b0;
      end
      if (g < 0) begin
        p = pick(req_valid, ptr_m);
        if (p >= 0) begin
          grant_m = N'(1) << p;
          bcnt    = 0;
        end
      end
    end
  endtask

  task automatic run_until_idle(string tag, int max);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      done = !mv && grant_m == '0;
      for (int n = 0; n < N; n++) if (head[n] != tail[n]) done = 1'b0;
    end
    chk(tag, done, 1);
  endtask

  task automatic clear_seen();
    seen_id.delete();
    seen_d.delete();
    seen_l.delete();
  endtask

  task automatic chk_seen(string tag, int ids[], int ds[], int ls[]);
    chk({tag, "_count"}, seen_id.size(), ids.size());
    for (int i = 0; i < ids.size() && i < seen_id.size(); i++) begin
      chk({tag, "_id"}, seen_id[i], ids[i]);
      chk({tag, "_data"}, seen_d[i], ds[i]);
      chk({tag, "_last"}, seen_l[i], ls[i]);
    end
  endtask

  initial begin
    int cnt;
    for (int n = 0; n < N; n++) begin
      head[n] = 0;
      tail[n] = 0;
    end
    model_reset();

    // reset
    rst_req = 1'b1;
    tick();
    tick();
    rst_req = 1'b0;
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", dp_valid, 0);
    chk("rst_data", dp_data, 0);
    chk("rst_id", dp_id, 0);
    chk("rst_last", dp_last, 0);

    // priority rotation, one-beat bursts
    clear_seen();
    for (int n = 0; n < N; n++) begin
      push(n, 8'h10 + 8'(n), 1'b1);
      push(n, 8'h20 + 8'(n), 1'b1);
    end
    run_until_idle("s1_idle", 100);
    chk_seen("s1", '{0, 1, 2, 3, 0, 1, 2, 3},
             '{'h10, 'h11, 'h12, 'h13, 'h20, 'h21, 'h22, 'h23},
             '{1, 1, 1, 1, 1, 1, 1, 1});

    // burst limit then re-grant
    clear_seen();
    for (int i = 0; i < 6; i++) push(2, 8'hA0 + 8'(i), i == 5);
    run_until_idle("s2_idle", 100);
    chk_seen("s2", '{2, 2, 2, 2, 2, 2},
             '{'hA0, 'hA1, 'hA2, 'hA3, 'hA4, 'hA5},
             '{0, 0, 0, 1, 0, 1});

    // downstream stall mid-burst
    clear_seen();
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    rdy_mode = 1;
    tick();
    tick();
    tick();
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s3_stall_ready", req_ready, 0);
      chk("s3_stall_data", dp_data, 'h22);
    end
    rdy_mode = 1;
    run_until_idle("s3_idle", 100);
    chk_seen("s3", '{1, 1, 1}, '{'h11, 'h22, 'h33}, '{0, 0, 1});

    // granted requester drops valid
    clear_seen();
    push(3, 8'h31, 1'b0);
    push(3, 8'h32, 1'b0);
    push(3, 8'h33, 1'b1);
    push(0, 8'h01, 1'b1);
    tick();
    tick();
    en = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("s4_grant_held", grant, 4'b1000);
      chk("s4_other_ready", req_ready & 4'b0111, 0);
    end
    en = '1;
    run_until_idle("s4_idle", 100);
    chk_seen("s4", '{3, 3, 3, 0}, '{'h31, 'h32, 'h33, 'h01}, '{0, 0, 1, 1});

    // pointer wrap after requester 2
    clear_seen();
    push(2, 8'h5A, 1'b1);
    run_until_idle("s5a_idle", 50);
    push(0, 8'h50, 1'b1);
    push(1, 8'h51, 1'b1);
    run_until_idle("s5b_idle", 50);
    chk_seen("s5", '{2, 0, 1}, '{'h5A, 'h50, 'h51}, '{1, 1, 1});

    // reset while a beat is stalled in the output register
    clear_seen();
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b0);
    push(1, 8'h63, 1'b1);
    rdy_mode = 0;
    tick();
    tick();
    tick();
    chk("s6_pre_valid", dp_valid, 1);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    chk("s6_grant", grant, 0);
    chk("s6_ready", req_ready, 0);
    chk("s6_valid", dp_valid, 0);
    chk("s6_data", dp_data, 0);
    chk("s6_id", dp_id, 0);
    chk("s6_last", dp_last, 0);
    clear_seen();
    push(1, 8'h71, 1'b1);
    push(3, 8'h73, 1'b1);
    rdy_mode = 1;
    run_until_idle("s6_idle", 50);
    chk_seen("s6", '{1, 3}, '{'h71, 'h73}, '{1, 1});

    // random traffic
    rand_en  = 1'b1;
    rdy_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < N; n++) begin
        cnt = $urandom_range(0, 12);
        for (int i = 0; i < cnt; i++)
          push(n, W'($urandom), (i == cnt - 1) || ($urandom_range(0, 3) == 0));
      end
      run_until_idle("rand_idle", 3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
